hog_bridge_ctrl: RTL and testbench



---
 rtl/hog_bridge_pkg.sv | 32 +++
 rtl/hog_desc_fifo.sv | 51 +++++
 rtl/hog_bridge_ctrl.sv | 129 ++++++++++++
 tb/tb_hog_bridge_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hog_bridge_pkg.sv
// Shared definitions for the HOG descriptor bridge: register offsets, CTRL/STATUS
// bit positions, bus FSM states and a byte-lane write merge helper.
package hog_bridge_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_THRESH = 2;
    localparam int REG_DATA   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_SRST   = 2;

    localparam int ST_EMPTY = 8;
    localparam int ST_FULL  = 9;
    localparam int ST_IRQ   = 10;
    localparam int ST_UNDER = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } bus_state_e;

    // Only the low 16 register bits exist; each byte lane has its own enable.
    function automatic logic [15:0] merge16(input logic [15:0] old,
                                            input logic [15:0] wd,
                                            input logic [1:0]  be);
        return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction

endpackage

// File: rtl/hog_desc_fifo.sv
// Synchronous descriptor FIFO with first-word-fall-through head and a flush
// that empties it and discards any push in the same cycle.
module hog_desc_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hog_bridge_ctrl.sv
// Bridge slave exposing the HOG descriptor FIFO through CTRL/STATUS/THRESH/DATA
// registers, with IDLE->ACK->WAIT handshake and a threshold interrupt.
module hog_bridge_ctrl
    import hog_bridge_pkg::*;
#(
    parameter int BUS_WIDTH  = 128,
    parameter int BUS_BYTES  = BUS_WIDTH / 8,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  bus_enable,
    input  logic                  r_wbar,
    input  logic [BUS_WIDTH-1:0]  write_data,
    input  logic [BUS_BYTES-1:0]  byte_enable,
    output logic [BUS_WIDTH-1:0]  read_data,
    output logic                  ack,
    output logic                  irq,
    input  logic [BUS_WIDTH-1:0]  desc_data,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    output logic                  hog_enable,
    output logic                  hog_soft_reset
);
    bus_state_e state, state_nxt;

    logic                 enable, irq_en, underflow;
    logic [CNT_W-1:0]     thresh, thr_eff, count;
    logic                 full, empty;
    logic [BUS_WIDTH-1:0] head, rd_mux;
    logic [15:0]          status_word;
    logic                 accept, wr, rd, wr_ctrl, soft_rst, rd_data, push, pop;
    logic                 unused_bits;

    assign unused_bits = ^{write_data[BUS_WIDTH-1:16], byte_enable[BUS_BYTES-1:2]};

    assign accept   = (state == S_IDLE) & bus_enable;
    assign wr       = accept & ~r_wbar;
    assign rd       = accept & r_wbar;
    assign rd_data  = rd & (addr == ADDR_WIDTH'(REG_DATA));
    assign wr_ctrl  = wr & (addr == ADDR_WIDTH'(REG_CTRL)) & byte_enable[0];
    assign soft_rst = wr_ctrl & write_data[CTRL_SRST];
    assign pop      = rd_data & ~empty;

    assign desc_ready = enable & ~full;
    assign push       = desc_valid & desc_ready;
    assign hog_enable = enable;
    assign ack        = (state == S_ACK);

    hog_desc_fifo #(.W(BUS_WIDTH), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (desc_data),
        .pop   (pop),
        .flush (soft_rst),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus_enable) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_WAIT;
            S_WAIT:  if (!bus_enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        status_word            = '0;
        status_word[CNT_W-1:0] = count;
        status_word[ST_EMPTY]  = empty;
        status_word[ST_FULL]   = full;
        status_word[ST_IRQ]    = irq;
        status_word[ST_UNDER]  = underflow;
        rd_mux = '0;
        case (addr)
            ADDR_WIDTH'(REG_CTRL):   rd_mux = BUS_WIDTH'({irq_en, enable});
            ADDR_WIDTH'(REG_STATUS): rd_mux = BUS_WIDTH'(status_word);
            ADDR_WIDTH'(REG_THRESH): rd_mux = BUS_WIDTH'(thresh);
            ADDR_WIDTH'(REG_DATA):   rd_mux = empty ? '0 : head;
            default:                 rd_mux = '0;
        endcase
    end

    // A zero threshold behaves as one so an empty FIFO never interrupts.
    assign thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable         <= 1'b0;
            irq_en         <= 1'b0;
            thresh         <= CNT_W'(FIFO_DEPTH / 2);
            underflow      <= 1'b0;
            hog_soft_reset <= 1'b0;
            irq            <= 1'b0;
            read_data      <= '0;
        end else begin
            hog_soft_reset <= soft_rst;
            irq            <= irq_en & (count >= thr_eff);
            if (rd) read_data <= rd_mux;
            if (wr_ctrl) begin
                enable <= write_data[CTRL_EN];
                irq_en <= write_data[CTRL_IRQ_EN];
            end
            if (wr && addr == ADDR_WIDTH'(REG_THRESH))
                thresh <= CNT_W'(merge16(16'(thresh), write_data[15:0], byte_enable[1:0]));
            if (soft_rst)
                underflow <= 1'b0;
            else if (rd_data && empty)
                underflow <= 1'b1;
            else if (wr && addr == ADDR_WIDTH'(REG_STATUS) && byte_enable[1] && write_data[ST_UNDER])
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hog_bridge_ctrl.sv
// Bench for hog_bridge_ctrl: directed scenarios then random bus/descriptor traffic,
// all checked against a queue-based register/FIFO model.
module tb_hog_bridge_ctrl;
    localparam int FD = 16;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [4:0]   addr = '0;
    logic         bus_enable = 1'b0, r_wbar = 1'b0;
    logic [127:0] write_data = '0;
    logic [15:0]  byte_enable = '0;
    logic [127:0] read_data;
    logic         ack, irq;
    logic [127:0] desc_data = '0;
    logic         desc_valid = 1'b0;
    logic         desc_ready, hog_enable, hog_soft_reset;

    always #5 clk = ~clk;

    hog_bridge_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .bus_enable(bus_enable), .r_wbar(r_wbar),
        .write_data(write_data), .byte_enable(byte_enable), .read_data(read_data),
        .ack(ack), .irq(irq), .desc_data(desc_data), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .hog_enable(hog_enable), .hog_soft_reset(hog_soft_reset)
    );

    int n_chk = 0, n_err = 0;

    logic [127:0] m_q[$];
    bit           m_en, m_ien, m_und, m_irq;
    int           m_thr;
    logic [127:0] m_rd;
    int           src_left;
    bit           src_rand;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_en = 0; m_ien = 0; m_und = 0; m_irq = 0; m_thr = FD / 2; m_rd = '0;
        src_left = 0; desc_valid = 0;
    endtask

    // One clock edge: apply the register/FIFO rules to the pre-edge model state,
    // then compare the visible outputs after the edge.
    task automatic step(input bit acc);
        int n, thr_eff;
        bit push, pop, flush, srst, irq_nx;
        n = m_q.size(); pop = 0; flush = 0; srst = 0;
        thr_eff = (m_thr == 0) ? 1 : m_thr;
        irq_nx = m_ien && (n >= thr_eff);
        push = desc_valid && m_en && (n < FD);
        if (acc && r_wbar) begin
            case (addr)
                5'd0: m_rd = {126'b0, m_ien, m_en};
                5'd1: m_rd = 128'(n) | (128'(n == 0) << 8) | (128'(n == FD) << 9)
                           | (128'(m_irq) << 10) | (128'(m_und) << 11);
                5'd2: m_rd = 128'(m_thr);
                5'd3: if (n > 0) begin m_rd = m_q[0]; pop = 1; end
                      else begin m_rd = '0; m_und = 1; end
                default: m_rd = '0;
            endcase
        end else if (acc) begin
            if (addr == 5'd0 && byte_enable[0]) begin
                m_en = write_data[0]; m_ien = write_data[1];
                if (write_data[2]) begin flush = 1; srst = 1; m_und = 0; end
            end
            if (addr == 5'd1 && byte_enable[1] && write_data[11]) m_und = 0;
            if (addr == 5'd2 && byte_enable[0]) m_thr = int'(write_data[4:0]);
        end
        @(posedge clk);
        if (flush) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(desc_data);
        end
        m_irq = irq_nx;
        #1;
        if (push) begin
            src_left--;
            if (src_rand) desc_data = {$urandom, $urandom, $urandom, $urandom};
            else desc_data = desc_data + 1;
        end
        desc_valid = (src_left > 0) && (!src_rand || ($urandom % 4 != 0));
        chk("ack", ack, acc);
        chk("irq", irq, m_irq);
        chk("desc_ready", desc_ready, m_en && (m_q.size() < FD));
        chk("hog_enable", hog_enable, m_en);
        chk("soft_reset", hog_soft_reset, srst);
    endtask

    task automatic bus(input bit rd, input logic [4:0] a, input logic [127:0] wd,
                       input logic [15:0] be, output logic [127:0] rdo);
        int hold;
        r_wbar = rd; addr = a; write_data = wd; byte_enable = be; bus_enable = 1;
        step(1);
        if (rd) chk("read_data", read_data, m_rd);
        rdo = read_data;
        hold = $urandom_range(0, 2);
        repeat (hold) step(0);
        bus_enable = 0;
        repeat (hold == 0 ? 2 : 1) step(0);
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [127:0] rdo);
        bus(1, a, '0, '0, rdo);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [127:0] wd, input logic [15:0] be);
        logic [127:0] dummy;
        bus(0, a, wd, be, dummy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded got %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [127:0] rdo;
        int guard;
        model_reset();
        src_rand = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ready", desc_ready, 0);
        chk("rst_srst", hog_soft_reset, 0);
        chk("rst_rdata", read_data, 0);
        rst_n = 1;

        rd_reg(5'd1, rdo); chk("st_rst", rdo[15:0], 16'h0100);
        rd_reg(5'd2, rdo); chk("thr_rst", rdo, 128'd8);

        wr_reg(5'd0, 128'h3, 16'h0001);
        desc_data = 128'h1; src_left = 8; desc_valid = 1;
        repeat (12) step(0);
        rd_reg(5'd1, rdo); chk("st_8", rdo[15:0], 16'h0408);

        for (int i = 0; i < 4; i++) begin
            rd_reg(5'd3, rdo); chk("pop_order", rdo, 128'(i + 1));
        end
        rd_reg(5'd1, rdo); chk("st_4", rdo[4:0], 5'd4);

        src_left = 20; desc_valid = 1;
        repeat (16) step(0);
        chk("full_ready", desc_ready, 0);
        rd_reg(5'd1, rdo); chk("st_full", rdo[15:0], 16'h0610);
        guard = 0;
        while ((m_q.size() > 0 || src_left > 0) && guard < 80) begin
            rd_reg(5'd3, rdo);
            guard++;
        end
        chk("drain_done", guard < 80, 1);
        rd_reg(5'd3, rdo); chk("empty_data", rdo, 0);
        rd_reg(5'd1, rdo); chk("under_set", rdo[11], 1);
        wr_reg(5'd1, 128'h800, 16'h0002);
        rd_reg(5'd1, rdo); chk("under_clr", rdo[11], 0);

        src_left = 5; desc_valid = 1;
        repeat (8) step(0);
        rd_reg(5'd1, rdo); chk("st_5", rdo[4:0], 5'd5);
        wr_reg(5'd0, 128'h7, 16'h0001);
        rd_reg(5'd0, rdo); chk("ctrl_rd", rdo[15:0], 16'h3);
        rd_reg(5'd1, rdo); chk("st_flush", rdo[15:0], 16'h0100);

        r_wbar = 1; addr = 5'd1; bus_enable = 1;
        step(1);
        rst_n = 0;
        #1;
        chk("midrst_ack", ack, 0);
        chk("midrst_en", hog_enable, 0);
        model_reset();
        bus_enable = 0;
        @(posedge clk);
        #1 rst_n = 1;
        rd_reg(5'd0, rdo); chk("midrst_ctrl", rdo, 0);

        src_rand = 1; src_left = 1000000;
        desc_data = {$urandom, $urandom, $urandom, $urandom};
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [4:0] a;
            logic [127:0] wd;
            r = $urandom_range(0, 11);
            if (r < 3) begin
                repeat ($urandom_range(1, 4)) step(0);
            end else begin
                a = (r < 10) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(4, 31));
                wd = {$urandom, $urandom, $urandom, $urandom};
                wd[0] = ($urandom % 4 != 0);
                wd[2] = ($urandom % 8 == 0);
                if ($urandom % 2) rd_reg(a, rdo);
                else wr_reg(a, wd, 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
